// File: rtl/asteroid_renderer.sv
// Asteroid renderer: erases the eight asteroids at their previously drawn
// positions, then draws them at the positions sampled when the frame starts.
// Streams one pixel per cycle to the VGA adapter, with off-screen pixels
// clipped. Handshakes with the game FSM via a level iStart / oDone pair.
module asteroid_renderer #(
    parameter int          SIZE      = 4,
    parameter int          SCREEN_W  = 160,
    parameter int          SCREEN_H  = 120,
    parameter logic [2:0]  DRAW_COL  = 3'b111,
    parameter logic [2:0]  ERASE_COL = 3'b000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        iStart,
    input  logic        iClear,
    input  logic [63:0] iX,
    input  logic [55:0] iY,
    output logic [7:0]  oX,
    output logic [6:0]  oY,
    output logic [2:0]  oColour,
    output logic        oPlot,
    output logic        oDone
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // The pixel index is kept as separate column/row counters, which gives
    // the row-major dx = px % SIZE, dy = px / SIZE walk without a divider.
    localparam logic [2:0] SZ_M1 = 3'(SIZE - 1);
    localparam logic [8:0] W_LIM = 9'(SCREEN_W);
    localparam logic [7:0] H_LIM = 8'(SCREEN_H);

    state_t     state;
    logic [2:0] ast;
    logic [2:0] dx;
    logic [2:0] dy;
    logic       prev_valid;
    logic [7:0] cur_x  [8];
    logic [6:0] cur_y  [8];
    logic [7:0] prev_x [8];
    logic [6:0] prev_y [8];

    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [8:0] x_sum;
    logic [7:0] y_sum;
    logic       visible;

    // Pixel address for the current asteroid/offset and its visibility.
    // Sums are one bit wider than the screen coordinates so pixels that run
    // off the right or bottom edge are clipped instead of wrapping.
    always_comb begin
        base_x = 8'd0;
        base_y = 7'd0;
        if (state == ERASE) begin
            base_x = prev_x[ast];
            base_y = prev_y[ast];
        end else begin
            base_x = cur_x[ast];
            base_y = cur_y[ast];
        end
        x_sum   = {1'b0, base_x} + {6'd0, dx};
        y_sum   = {1'b0, base_y} + {5'd0, dy};
        visible = (x_sum < W_LIM) && (y_sum < H_LIM);
    end

    // Frame sequencer: IDLE -> [ERASE] -> DRAW -> DONE, with registered outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            ast        <= 3'd0;
            dx         <= 3'd0;
            dy         <= 3'd0;
            prev_valid <= 1'b0;
            oX         <= 8'd0;
            oY         <= 7'd0;
            oColour    <= 3'd0;
            oPlot      <= 1'b0;
            oDone      <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                cur_x[i]  <= 8'd0;
                cur_y[i]  <= 7'd0;
                prev_x[i] <= 8'd0;
                prev_y[i] <= 7'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    oPlot <= 1'b0;
                    oDone <= 1'b0;
                    if (iClear) begin
                        prev_valid <= 1'b0;
                    end
                    if (iStart) begin
                        for (int i = 0; i < 8; i++) begin
                            cur_x[i] <= iX[8*i +: 8];
                            cur_y[i] <= iY[7*i +: 7];
                        end
                        ast <= 3'd0;
                        dx  <= 3'd0;
                        dy  <= 3'd0;
                        // A same-edge clear means nothing on screen to erase.
                        state <= (prev_valid && !iClear) ? ERASE : DRAW;
                    end
                end
                ERASE, DRAW: begin
                    oX      <= x_sum[7:0];
                    oY      <= y_sum[6:0];
                    oColour <= (state == ERASE) ? ERASE_COL : DRAW_COL;
                    oPlot   <= visible;
                    oDone   <= 1'b0;
                    if (dx != SZ_M1) begin
                        dx <= dx + 3'd1;
                    end else begin
                        dx <= 3'd0;
                        if (dy != SZ_M1) begin
                            dy <= dy + 3'd1;
                        end else begin
                            dy <= 3'd0;
                            if (ast != 3'd7) begin
                                ast <= ast + 3'd1;
                            end else begin
                                ast <= 3'd0;
                                if (state == ERASE) begin
                                    state <= DRAW;
                                end else begin
                                    for (int i = 0; i < 8; i++) begin
                                        prev_x[i] <= cur_x[i];
                                        prev_y[i] <= cur_y[i];
                                    end
                                    prev_valid <= 1'b1;
                                    state      <= DONE;
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    oPlot <= 1'b0;
                    // First DONE edge always raises oDone so it is seen for at
                    // least one cycle, even if iStart already dropped.
                    if (!oDone) begin
                        oDone <= 1'b1;
                    end else if (!iStart) begin
                        oDone <= 1'b0;
                        state <= IDLE;
                    end else begin
                        oDone <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    oPlot <= 1'b0;
                    oDone <= 1'b0;
                end
            endcase
        end
    end

endmodule
